// File: rtl/uart_rx.sv
// uart_rx: parametrised UART receiver with 3-sample majority voting, parity/framing/break
// detection, start-glitch rejection and a one-word ready/valid output buffer.
module uart_rx #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned MSB_FIRST  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_break,
    output logic                 rx_overrun,
    output logic                 rx_busy
);
    localparam int unsigned DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned S_W     = $clog2(OVERSAMPLE);
    localparam int unsigned BC_W    = $clog2(DATA_BITS);

    localparam logic [S_W-1:0]   S_LO    = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [S_W-1:0]   S_MID   = S_W'(OVERSAMPLE / 2);
    localparam logic [S_W-1:0]   S_DEC   = S_W'(OVERSAMPLE / 2 + 1);
    localparam logic [S_W-1:0]   S_LAST  = S_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0]  BC_LAST = BC_W'(DATA_BITS - 1);
    // The detection cycle itself is the first clock of sample 0.
    localparam logic [DIV_W-1:0] DIV_START = DIV_W'((DIV == 1) ? 0 : 1);
    localparam logic [S_W-1:0]   S_START   = S_W'((DIV == 1) ? 1 : 0);

    typedef enum logic [2:0] {
        StIdle, StStart, StData, StParity, StStop, StBreakWait
    } state_e;

    state_e               state_q, state_d;
    logic                 sync_q, rxs_q;
    logic [DIV_W-1:0]     div_cnt_q;
    logic [S_W-1:0]       s_q;
    logic [1:0]           samp_q;
    logic [BC_W-1:0]      bit_cnt_q;
    logic                 stop_cnt_q;
    logic [DATA_BITS-1:0] shift_q, shift_in;
    logic                 par_vote_q, par_err_q, frm_err_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q, pe_q, fe_q, brk_q, ovr_q;

    logic tick, decide, wrap, vote, sampling, last_stop, par_exp;
    logic start_det, frame_done, frame_fe, is_break;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 1'b1;
            rxs_q  <= 1'b1;
        end else begin
            sync_q <= rx;
            rxs_q  <= sync_q;
        end
    end

    assign tick      = (div_cnt_q == DIV_W'(DIV - 1));
    assign decide    = tick && (s_q == S_DEC);
    assign wrap      = tick && (s_q == S_LAST);
    assign vote      = (samp_q[1] & samp_q[0]) | (samp_q[1] & rxs_q) | (samp_q[0] & rxs_q);
    assign last_stop = (stop_cnt_q == 1'(STOP_BITS - 1));
    assign par_exp   = (^shift_q) ^ (PARITY == 2);
    assign frame_fe  = frm_err_q | ~vote;
    assign is_break  = (shift_q == '0) && ((PARITY == 0) || !par_vote_q) && frame_fe;

    always_comb begin
        if (MSB_FIRST != 0) shift_in = {shift_q[DATA_BITS-2:0], vote};
        else                shift_in = {vote, shift_q[DATA_BITS-1:1]};
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:      if (!rxs_q) state_d = StStart;
            StStart: begin
                if (decide && vote) state_d = StIdle;
                else if (wrap)      state_d = StData;
            end
            StData:      if (wrap && bit_cnt_q == BC_LAST)
                             state_d = (PARITY != 0) ? StParity : StStop;
            StParity:    if (wrap) state_d = StStop;
            StStop:      if (decide && last_stop) state_d = is_break ? StBreakWait : StIdle;
            StBreakWait: if (rxs_q) state_d = StIdle;
            default:     state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        start_det  = (state_q == StIdle) && !rxs_q;
        frame_done = (state_q == StStop) && decide && last_stop;
        sampling   = (state_q == StStart) || (state_q == StData) ||
                     (state_q == StParity) || (state_q == StStop);
        rx_busy    = (state_q != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q  <= '0;
            s_q        <= '0;
            samp_q     <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            par_vote_q <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
        end else if (start_det) begin
            div_cnt_q  <= DIV_START;
            s_q        <= S_START;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_vote_q <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
        end else if (sampling) begin
            if (tick) begin
                div_cnt_q <= '0;
                s_q       <= (s_q == S_LAST) ? '0 : s_q + 1'b1;
            end else begin
                div_cnt_q <= div_cnt_q + 1'b1;
            end
            if (tick && s_q == S_LO)  samp_q[1] <= rxs_q;
            if (tick && s_q == S_MID) samp_q[0] <= rxs_q;
            if (decide) begin
                case (state_q)
                    StData:   shift_q <= shift_in;
                    StParity: begin
                        par_vote_q <= vote;
                        par_err_q  <= vote ^ par_exp;
                    end
                    StStop:   if (!vote) frm_err_q <= 1'b1;
                    default:  ;
                endcase
            end
            if (wrap && state_q == StData) bit_cnt_q  <= bit_cnt_q + 1'b1;
            if (wrap && state_q == StStop) stop_cnt_q <= ~stop_cnt_q;
        end
    end

    // Output buffer: a completed frame is dropped only when the held word is not being taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            brk_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (frame_done && (!valid_q || rx_ready)) begin
                valid_q <= 1'b1;
                data_q  <= shift_q;
                pe_q    <= par_err_q;
                fe_q    <= frame_fe;
                brk_q   <= is_break;
            end else begin
                if (frame_done)           ovr_q   <= 1'b1;
                if (valid_q && rx_ready)  valid_q <= 1'b0;
            end
        end
    end

    assign rx_data       = data_q;
    assign rx_valid      = valid_q;
    assign rx_parity_err = pe_q;
    assign rx_frame_err  = fe_q;
    assign rx_break      = brk_q;
    assign rx_overrun    = ovr_q;

endmodule
